// File: rtl/conv2d_seq.sv
// Sequential 2-D convolution: one multiply-accumulate per cycle, results
// streamed in raster order over a valid/ready handshake.
module conv2d_seq #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned IFMAP_SIZE  = 5,
  parameter int unsigned FILTER_SIZE = 3,
  parameter int unsigned STRIDE      = 1,
  localparam int unsigned K          = FILTER_SIZE,
  localparam int unsigned OFMAP_SIZE = (IFMAP_SIZE - K) / STRIDE + 1,
  localparam int unsigned ACC_W      = 2 * DATA_W + $clog2(K * K),
  localparam int unsigned IDX_W      = ($clog2(OFMAP_SIZE) > 1) ? $clog2(OFMAP_SIZE) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [IFMAP_SIZE*IFMAP_SIZE*DATA_W-1:0] ifmap,
  input  logic [K*K*DATA_W-1:0]                 filter,
  output logic                                  busy,
  output logic                                  ofmap_valid,
  input  logic                                  ofmap_ready,
  output logic [ACC_W-1:0]                      ofmap_data,
  output logic [IDX_W-1:0]                      ofmap_row,
  output logic [IDX_W-1:0]                      ofmap_col,
  output logic                                  done
);

  localparam int unsigned NPIX   = IFMAP_SIZE * IFMAP_SIZE;
  localparam int unsigned NTAP   = K * K;
  localparam int unsigned PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned TAPI_W = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int unsigned TAP_W  = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W;

  if (K > IFMAP_SIZE) begin : g_bad_filter
    $error("FILTER_SIZE must not exceed IFMAP_SIZE");
  end
  if (((IFMAP_SIZE - K) % STRIDE) != 0) begin : g_bad_stride
    $error("IFMAP_SIZE-FILTER_SIZE must be divisible by STRIDE");
  end

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] img  [NPIX];
  logic [DATA_W-1:0] coef [NTAP];
  logic [ACC_W-1:0]  acc;
  logic [TAP_W-1:0]  tap_u, tap_v;

  logic              load, mac_step, fire;
  logic              last_tap, last_pos;
  logic [PIX_W-1:0]  pix_idx;
  logic [TAPI_W-1:0] tap_idx;
  logic [PROD_W-1:0] product;
  logic [ACC_W-1:0]  acc_next;

  assign last_tap = (tap_u == TAP_W'(K - 1)) && (tap_v == TAP_W'(K - 1));
  assign last_pos = (ofmap_row == IDX_W'(OFMAP_SIZE - 1)) && (ofmap_col == IDX_W'(OFMAP_SIZE - 1));

  // Window tap address and the product it contributes this cycle.
  always_comb begin
    pix_idx  = PIX_W'((32'(ofmap_row) * STRIDE + 32'(tap_u)) * IFMAP_SIZE
                      + 32'(ofmap_col) * STRIDE + 32'(tap_v));
    tap_idx  = TAPI_W'(32'(tap_u) * K + 32'(tap_v));
    product  = PROD_W'(img[pix_idx]) * PROD_W'(coef[tap_idx]);
    acc_next = acc + ACC_W'(product);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MAC;
      MAC:     if (last_tap) state_next = OUT;
      OUT:     if (ofmap_valid && ofmap_ready) state_next = last_pos ? IDLE : MAC;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    mac_step = 1'b0;
    fire     = 1'b0;
    case (state)
      IDLE:    load     = start;
      MAC:     mac_step = 1'b1;
      OUT:     fire     = ofmap_valid && ofmap_ready;
      default: ;
    endcase
  end

  // Operand storage, accumulator, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NPIX); i++) img[i] <= '0;
      for (int i = 0; i < int'(NTAP); i++) coef[i] <= '0;
      acc         <= '0;
      tap_u       <= '0;
      tap_v       <= '0;
      ofmap_row   <= '0;
      ofmap_col   <= '0;
      ofmap_data  <= '0;
      ofmap_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        for (int i = 0; i < int'(NPIX); i++) img[i] <= ifmap[i*DATA_W +: DATA_W];
        for (int i = 0; i < int'(NTAP); i++) coef[i] <= filter[i*DATA_W +: DATA_W];
        acc       <= '0;
        tap_u     <= '0;
        tap_v     <= '0;
        ofmap_row <= '0;
        ofmap_col <= '0;
        busy      <= 1'b1;
      end
      if (mac_step) begin
        acc <= acc_next;
        if (last_tap) begin
          tap_u       <= '0;
          tap_v       <= '0;
          ofmap_valid <= 1'b1;
          ofmap_data  <= acc_next;
        end else if (tap_v == TAP_W'(K - 1)) begin
          tap_v <= '0;
          tap_u <= tap_u + TAP_W'(1);
        end else begin
          tap_v <= tap_v + TAP_W'(1);
        end
      end
      if (fire) begin
        ofmap_valid <= 1'b0;
        acc         <= '0;
        if (last_pos) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else if (ofmap_col == IDX_W'(OFMAP_SIZE - 1)) begin
          ofmap_col <= '0;
          ofmap_row <= ofmap_row + IDX_W'(1);
        end else begin
          ofmap_col <= ofmap_col + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2d_seq.sv
// Bench for conv2d_seq: stride-1 and stride-2 instances compared against a
// plain-arithmetic convolution of the frame loaded at start.
module tb_conv2d_seq;

  localparam int unsigned DW = 8;
  localparam int unsigned N  = 5;
  localparam int unsigned K  = 3;
  localparam int unsigned AW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, ready_a, busy_a, valid_a, done_a;
  logic [N*N*DW-1:0] ifmap_a;
  logic [K*K*DW-1:0] filter_a;
  logic [AW-1:0]     data_a;
  logic [1:0]        row_a, col_a;

  logic start_b, ready_b, busy_b, valid_b, done_b;
  logic [N*N*DW-1:0] ifmap_b;
  logic [K*K*DW-1:0] filter_b;
  logic [AW-1:0]     data_b;
  logic              row_b, col_b;

  int checks   = 0;
  int failures = 0;

  int unsigned img [N][N];
  int unsigned flt [K][K];

  conv2d_seq dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ifmap(ifmap_a), .filter(filter_a),
    .busy(busy_a), .ofmap_valid(valid_a), .ofmap_ready(ready_a), .ofmap_data(data_a),
    .ofmap_row(row_a), .ofmap_col(col_a), .done(done_a)
  );

  conv2d_seq #(.STRIDE(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ifmap(ifmap_b), .filter(filter_b),
    .busy(busy_b), .ofmap_valid(valid_b), .ofmap_ready(ready_b), .ofmap_data(data_b),
    .ofmap_row(row_b), .ofmap_col(col_b), .done(done_b)
  );

  function automatic int unsigned ref_px(int s, int r, int c);
    int unsigned sum = 0;
    for (int u = 0; u < int'(K); u++)
      for (int v = 0; v < int'(K); v++)
        sum += img[r*s+u][c*s+v] * flt[u][v];
    return sum;
  endfunction

  task automatic drive_inputs();
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) begin
        ifmap_a[(r*N+c)*DW +: DW] = DW'(img[r][c]);
        ifmap_b[(r*N+c)*DW +: DW] = DW'(img[r][c]);
      end
    for (int u = 0; u < int'(K); u++)
      for (int v = 0; v < int'(K); v++) begin
        filter_a[(u*K+v)*DW +: DW] = DW'(flt[u][v]);
        filter_b[(u*K+v)*DW +: DW] = DW'(flt[u][v]);
      end
  endtask

  task automatic randomize_frame(input int unsigned lo);
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) img[r][c] = $urandom_range(255, lo);
    for (int u = 0; u < int'(K); u++)
      for (int v = 0; v < int'(K); v++) flt[u][v] = $urandom_range(255, lo);
  endtask

  // One stride-1 frame; optional back-pressure at the first result and
  // optional mid-frame disturbance of start/ifmap/filter.
  task automatic run_a(input string name, input int stall, input bit disturb, input bit tail);
    int unsigned exp_d [9];
    int cyc, idx, t;
    for (int i = 0; i < 9; i++) exp_d[i] = ref_px(1, i / 3, i % 3);
    drive_inputs();
    start_a = 1'b1;
    ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0;
    idx = 0;
    checks++;
    if (busy_a !== 1'b1 || valid_a !== 1'b0) begin
      failures++;
      $display("FAIL %s accept: busy=%b valid=%b, expected busy=1 valid=0", name, busy_a, valid_a);
    end
    while (idx < 9 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (disturb && cyc == 3) begin
        start_a = 1'b1;
        for (int i = 0; i < int'(N*N); i++) ifmap_a[i*DW +: DW] = DW'($urandom);
        for (int i = 0; i < int'(K*K); i++) filter_a[i*DW +: DW] = DW'($urandom);
      end
      if (disturb && cyc == 4) start_a = 1'b0;
      checks++;
      if (done_a !== 1'b0) begin
        failures++;
        $display("FAIL %s early_done: done=%b at cycle %0d, expected 0", name, done_a, cyc);
      end
      if (valid_a === 1'b1) begin
        t = cyc;
        if (idx == 0 && stall > 0) begin
          ready_a = 1'b0;
          for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (valid_a !== 1'b1 || data_a !== AW'(exp_d[0]) || row_a !== 2'd0 || col_a !== 2'd0) begin
              failures++;
              $display("FAIL %s hold: valid=%b data=%0d row=%0d col=%0d, expected 1 %0d 0 0",
                       name, valid_a, data_a, row_a, col_a, exp_d[0]);
            end
          end
          ready_a = 1'b1;
        end
        checks++;
        if (data_a !== AW'(exp_d[idx]) || row_a !== 2'(idx / 3) || col_a !== 2'(idx % 3)) begin
          failures++;
          $display("FAIL %s result[%0d]: data=%0d row=%0d col=%0d, expected %0d %0d %0d",
                   name, idx, data_a, row_a, col_a, exp_d[idx], idx / 3, idx % 3);
        end
        checks++;
        if (t != 9 + 10 * idx + ((idx > 0) ? stall : 0)) begin
          failures++;
          $display("FAIL %s timing[%0d]: valid at cycle %0d, expected %0d",
                   name, idx, t, 9 + 10 * idx + ((idx > 0) ? stall : 0));
        end
        idx++;
      end
    end
    checks++;
    if (idx != 9) begin
      failures++;
      $display("FAIL %s timeout: got %0d results, expected 9", name, idx);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || valid_a !== 1'b0) begin
      failures++;
      $display("FAIL %s done: done=%b busy=%b valid=%b, expected 1 0 0", name, done_a, busy_a, valid_a);
    end
    if (tail) begin
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        failures++;
        $display("FAIL %s done_pulse: done=%b busy=%b, expected 0 0", name, done_a, busy_a);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_a, valid_a, done_a, data_a, row_a, col_a} !== '0 ||
        {busy_b, valid_b, done_b, data_b, row_b, col_b} !== '0) begin
      failures++;
      $display("FAIL reset: a=%b/%b/%b/%0d/%0d/%0d b=%b/%b/%b/%0d, expected all zero",
               busy_a, valid_a, done_a, data_a, row_a, col_a, busy_b, valid_b, done_b, data_b);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0 || busy_b !== 1'b0 || valid_b !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy_a=%b valid_a=%b busy_b=%b valid_b=%b, expected 0",
               busy_a, valid_a, busy_b, valid_b);
    end
  endtask

  task automatic test_all_ones();
    for (int r = 0; r < int'(N); r++) for (int c = 0; c < int'(N); c++) img[r][c] = 1;
    for (int u = 0; u < int'(K); u++) for (int v = 0; v < int'(K); v++) flt[u][v] = 1;
    run_a("ones", 0, 1'b0, 1'b1);
  endtask

  task automatic test_ramp();
    for (int r = 0; r < int'(N); r++) for (int c = 0; c < int'(N); c++) img[r][c] = 5 * r + c;
    for (int u = 0; u < int'(K); u++) for (int v = 0; v < int'(K); v++) flt[u][v] = (u == 1 && v == 1) ? 1 : 0;
    run_a("ramp", 0, 1'b0, 1'b1);
  endtask

  task automatic test_stride2();
    int unsigned exp_d [4];
    int cyc, idx;
    for (int r = 0; r < int'(N); r++) for (int c = 0; c < int'(N); c++) img[r][c] = 5 * r + c;
    for (int u = 0; u < int'(K); u++) for (int v = 0; v < int'(K); v++) flt[u][v] = (u == 1 && v == 1) ? 1 : 0;
    for (int i = 0; i < 4; i++) exp_d[i] = ref_px(2, i / 2, i % 2);
    drive_inputs();
    ready_b = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 0;
    idx = 0;
    while (idx < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (valid_b === 1'b1) begin
        checks++;
        if (data_b !== AW'(exp_d[idx]) || row_b !== 1'(idx / 2) || col_b !== 1'(idx % 2) ||
            cyc != 9 + 10 * idx || done_b !== 1'b0) begin
          failures++;
          $display("FAIL stride2[%0d]: data=%0d row=%0d col=%0d cycle=%0d done=%b, expected %0d %0d %0d %0d 0",
                   idx, data_b, row_b, col_b, cyc, done_b, exp_d[idx], idx / 2, idx % 2, 9 + 10 * idx);
        end
        idx++;
      end
    end
    checks++;
    if (idx != 4) begin
      failures++;
      $display("FAIL stride2 timeout: got %0d results, expected 4", idx);
    end
    @(negedge clk);
    checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL stride2 done: done=%b busy=%b, expected 1 0", done_b, busy_b);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < int'(N); r++) for (int c = 0; c < int'(N); c++) img[r][c] = 255;
    for (int u = 0; u < int'(K); u++) for (int v = 0; v < int'(K); v++) flt[u][v] = 255;
    run_a("backpressure", 20, 1'b0, 1'b1);
  endtask

  task automatic test_ignore_inputs();
    randomize_frame(0);
    run_a("ignore_inputs", 0, 1'b1, 1'b1);
  endtask

  // Reset lands in the 4th MAC cycle of the second window.
  task automatic test_reset_mid();
    int unsigned first;
    randomize_frame(1);
    first = ref_px(1, 0, 0);
    drive_inputs();
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (13) @(negedge clk);
    checks++;
    if (busy_a !== 1'b1 || valid_a !== 1'b0 || data_a !== AW'(first) || col_a !== 2'd1) begin
      failures++;
      $display("FAIL pre_reset: busy=%b valid=%b data=%0d col=%0d, expected 1 0 %0d 1",
               busy_a, valid_a, data_a, col_a, first);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy_a, valid_a, done_a, data_a, row_a, col_a} !== '0) begin
      failures++;
      $display("FAIL async_reset: busy=%b valid=%b done=%b data=%0d row=%0d col=%0d, expected all zero",
               busy_a, valid_a, done_a, data_a, row_a, col_a);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || valid_a !== 1'b0 || done_a !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_idle: busy=%b valid=%b done=%b, expected 0 0 0", busy_a, valid_a, done_a);
      end
    end
    randomize_frame(0);
    run_a("after_reset", 0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    randomize_frame(0);
    run_a("b2b_first", 0, 1'b0, 1'b0);
    randomize_frame(0);
    run_a("b2b_second", 0, 1'b0, 1'b1);
  endtask

  initial begin
    rst      = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    ready_a  = 1'b1;
    ready_b  = 1'b1;
    ifmap_a  = '0;
    ifmap_b  = '0;
    filter_a = '0;
    filter_b = '0;
    test_reset();
    test_all_ones();
    test_ramp();
    test_stride2();
    test_backpressure();
    test_ignore_inputs();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
